// File: rtl/term_ctrl_if.sv
// Host register bus for the text terminal controller: one access per cycle,
// combinational status word returned on rdata.
interface term_ctrl_if #(
    parameter int DATA_BUS = 32
);
    logic                ena;
    logic                rw;
    logic [DATA_BUS-1:0] addr;
    logic [DATA_BUS-1:0] wdata;
    logic [DATA_BUS-1:0] rdata;

    modport master (
        output ena,
        output rw,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  ena,
        input  rw,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/term_ctrl.sv
// Text terminal controller: cursor tracking, character put, screen clear and,
// with macro TERM_SCROLL_EN defined, hardware scroll of a COLS x ROWS buffer.
module term_ctrl #(
    parameter int COLS = 70,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        rst,
    term_ctrl_if.slave  bus,
    output logic        buf_we,
    output logic [11:0] buf_waddr,
    output logic [7:0]  buf_wdata,
    output logic [11:0] buf_raddr,
    input  logic [7:0]  buf_rdata
);

    localparam logic        MEM_WRITE = 1'b1;
    localparam logic [11:0] COLS_W    = 12'(COLS);
    localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);
    localparam logic [11:0] LAST_COPY = 12'(COLS * (ROWS - 1) - 1);
    localparam logic [11:0] FIRST_BOT = 12'(COLS * (ROWS - 1));
    localparam logic [6:0]  COL_LAST  = 7'(COLS - 1);
    localparam logic [4:0]  ROW_LAST  = 5'(ROWS - 1);
    localparam logic [7:0]  BLANK     = 8'h20;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PUT    = 3'd1,
        SCR_RD = 3'd2,
        SCR_WR = 3'd3,
        FILL   = 3'd4
    } state_t;

    state_t      state_r;
    logic [4:0]  row_r;
    logic [6:0]  col_r;
    logic        ovr_r;
    logic [11:0] idx_r;
    logic        buf_we_r;
    logic [11:0] buf_waddr_r;
    logic [11:0] buf_raddr_r;
    logic [7:0]  buf_wdata_r;

    logic        wr_s;
    logic        rd_s;
    logic [7:0]  ch_s;
    logic        printable_s;
    logic        unused_bits_s;

    function automatic logic [11:0] cell_index(input logic [4:0] r, input logic [6:0] c);
        return ({7'd0, r} * COLS_W) + {5'd0, c};
    endfunction

    assign wr_s          = bus.ena && (bus.rw == MEM_WRITE);
    assign rd_s          = bus.ena && (bus.rw != MEM_WRITE);
    assign ch_s          = bus.wdata[7:0];
    assign printable_s   = (ch_s >= 8'h20) && (ch_s <= 8'h7E);
    assign unused_bits_s = ^{bus.addr[31:1], bus.wdata[31:8]};

    assign bus.rdata = {(state_r != IDLE), ovr_r, 17'd0, row_r, 1'b0, col_r};
    assign buf_we    = buf_we_r;
    assign buf_waddr = buf_waddr_r;
    assign buf_raddr = buf_raddr_r;
    // During a scroll copy the character comes straight from the buffer read port.
    assign buf_wdata = (state_r == SCR_WR) ? buf_rdata : buf_wdata_r;

    // Controller FSM: cursor, sticky overrun flag and buffer write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            row_r       <= 5'd0;
            col_r       <= 7'd0;
            ovr_r       <= 1'b0;
            idx_r       <= 12'd0;
            buf_we_r    <= 1'b0;
            buf_waddr_r <= 12'd0;
            buf_raddr_r <= 12'd0;
            buf_wdata_r <= 8'd0;
        end else begin
            if (rd_s) begin
                ovr_r <= 1'b0;
            end else if (wr_s && (state_r != IDLE)) begin
                ovr_r <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    buf_we_r <= 1'b0;
                    if (wr_s) begin
                        if (bus.addr[0]) begin
                            if (bus.wdata[0]) begin
                                row_r       <= 5'd0;
                                col_r       <= 7'd0;
                                idx_r       <= 12'd0;
                                buf_waddr_r <= 12'd0;
                                buf_wdata_r <= BLANK;
                                buf_we_r    <= 1'b1;
                                state_r     <= FILL;
                            end else if (bus.wdata[1]) begin
                                row_r <= 5'd0;
                                col_r <= 7'd0;
                            end
                        end else if (printable_s) begin
                            buf_waddr_r <= cell_index(row_r, col_r);
                            buf_wdata_r <= ch_s;
                            buf_we_r    <= 1'b1;
                            state_r     <= PUT;
                        end else if (ch_s == 8'h0A) begin
                            col_r <= 7'd0;
                            if (row_r != ROW_LAST) begin
                                row_r <= row_r + 5'd1;
                            end else begin
`ifdef TERM_SCROLL_EN
                                idx_r       <= 12'd0;
                                buf_raddr_r <= COLS_W;
                                state_r     <= SCR_RD;
`else
                                row_r <= 5'd0;
`endif
                            end
                        end else if (ch_s == 8'h0D) begin
                            col_r <= 7'd0;
                        end else if (ch_s == 8'h08) begin
                            if (col_r != 7'd0) begin
                                col_r <= col_r - 7'd1;
                            end
                        end
                    end
                end

                PUT: begin
                    buf_we_r <= 1'b0;
                    state_r  <= IDLE;
                    if (col_r != COL_LAST) begin
                        col_r <= col_r + 7'd1;
                    end else begin
                        col_r <= 7'd0;
                        if (row_r != ROW_LAST) begin
                            row_r <= row_r + 5'd1;
                        end else begin
`ifdef TERM_SCROLL_EN
                            idx_r       <= 12'd0;
                            buf_raddr_r <= COLS_W;
                            state_r     <= SCR_RD;
`else
                            row_r <= 5'd0;
`endif
                        end
                    end
                end

                SCR_RD: begin
                    buf_waddr_r <= idx_r;
                    buf_we_r    <= 1'b1;
                    state_r     <= SCR_WR;
                end

                SCR_WR: begin
                    if (idx_r == LAST_COPY) begin
                        idx_r       <= FIRST_BOT;
                        buf_waddr_r <= FIRST_BOT;
                        buf_wdata_r <= BLANK;
                        buf_we_r    <= 1'b1;
                        state_r     <= FILL;
                    end else begin
                        idx_r       <= idx_r + 12'd1;
                        buf_raddr_r <= idx_r + 12'd1 + COLS_W;
                        buf_we_r    <= 1'b0;
                        state_r     <= SCR_RD;
                    end
                end

                FILL: begin
                    if (idx_r == LAST_CELL) begin
                        buf_we_r <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        idx_r       <= idx_r + 12'd1;
                        buf_waddr_r <= idx_r + 12'd1;
                    end
                end

                default: begin
                    buf_we_r <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_term_ctrl.sv
// Directed bench for term_ctrl: a per-cycle expectation queue built from the
// terminal rules, a buffer memory model, and hand-computed literal checks.
`timescale 1ns/1ps
module tb_term_ctrl;

    localparam int C = 70;
    localparam int R = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        buf_we;
    logic [11:0] buf_waddr;
    logic [11:0] buf_raddr;
    logic [7:0]  buf_wdata;
    logic [7:0]  buf_rdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    term_ctrl_if bus ();

    term_ctrl #(.COLS(C), .ROWS(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .buf_we    (buf_we),
        .buf_waddr (buf_waddr),
        .buf_wdata (buf_wdata),
        .buf_raddr (buf_raddr),
        .buf_rdata (buf_rdata)
    );

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    // Character buffer with one-cycle read latency, preloaded with a pattern.
    logic [7:0] tb_mem [0:4095];
    logic       mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) tb_mem[i] <= pat(i);
            mem_ready <= 1'b1;
        end else if (buf_we) begin
            tb_mem[buf_waddr] <= buf_wdata;
        end
        buf_rdata <= tb_mem[buf_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        we;
        logic        rd;
        logic        cp;
        logic [11:0] addr;
        logic [11:0] src;
        logic [7:0]  data;
        int          row;
        int          col;
    } cyc_t;

    cyc_t       q[$];
    int         m_row = 0;
    int         m_col = 0;
    bit         m_ovr = 1'b0;
    bit         started = 1'b0;
    logic [7:0] exp_mem [0:4095];

    task automatic push_cyc(input logic we, input logic rd, input logic cp,
                            input int addr, input int src, input logic [7:0] data);
        cyc_t e;
        e.we = we; e.rd = rd; e.cp = cp;
        e.addr = 12'(addr); e.src = 12'(src); e.data = data;
        e.row = m_row; e.col = m_col;
        q.push_back(e);
    endtask

    task automatic model_overflow();
`ifdef TERM_SCROLL_EN
        m_row = R - 1;
        m_col = 0;
        for (int i = 0; i < C * (R - 1); i++) begin
            push_cyc(1'b0, 1'b1, 1'b0, i + C, 0, 8'h00);
            push_cyc(1'b1, 1'b0, 1'b1, i, i + C, 8'h00);
        end
        for (int i = C * (R - 1); i < C * R; i++) push_cyc(1'b1, 1'b0, 1'b0, i, 0, 8'h20);
`else
        m_row = 0;
        m_col = 0;
`endif
    endtask

    task automatic model_write(input logic a0, input logic [7:0] d);
        if (a0) begin
            if (d[0]) begin
                m_row = 0;
                m_col = 0;
                for (int i = 0; i < C * R; i++) push_cyc(1'b1, 1'b0, 1'b0, i, 0, 8'h20);
            end else if (d[1]) begin
                m_row = 0;
                m_col = 0;
            end
        end else if (d >= 8'h20 && d <= 8'h7E) begin
            push_cyc(1'b1, 1'b0, 1'b0, m_row * C + m_col, 0, d);
            if (m_col < C - 1) m_col++;
            else begin
                m_col = 0;
                if (m_row < R - 1) m_row++;
                else model_overflow();
            end
        end else if (d == 8'h0A) begin
            m_col = 0;
            if (m_row < R - 1) m_row++;
            else model_overflow();
        end else if (d == 8'h0D) begin
            m_col = 0;
        end else if (d == 8'h08) begin
            if (m_col > 0) m_col--;
        end
    endtask

    // Compare DUT outputs with the expected cycle, then apply this cycle's access.
    always @(negedge clk) begin
        cyc_t        e;
        bit          busy_now;
        logic [7:0]  exp_d;
        busy_now = 1'b0;
        if (!started) begin
            for (int i = 0; i < 4096; i++) exp_mem[i] = pat(i);
        end else if (q.size() > 0) begin
            e = q.pop_front();
            busy_now = 1'b1;
            chk("rdata_busy", bus.rdata,
                {1'b1, m_ovr, 17'd0, 5'(e.row), 1'b0, 7'(e.col)});
            chk("buf_we", {31'd0, buf_we}, {31'd0, e.we});
            if (e.we) begin
                exp_d = e.cp ? exp_mem[e.src] : e.data;
                chk("buf_waddr", {20'd0, buf_waddr}, {20'd0, e.addr});
                chk("buf_wdata", {24'd0, buf_wdata}, {24'd0, exp_d});
                exp_mem[e.addr] = exp_d;
            end
            if (e.rd) chk("buf_raddr", {20'd0, buf_raddr}, {20'd0, e.addr});
        end else begin
            chk("rdata_idle", bus.rdata,
                {1'b0, m_ovr, 17'd0, 5'(m_row), 1'b0, 7'(m_col)});
            chk("buf_we_idle", {31'd0, buf_we}, 32'd0);
        end

        if (rst) begin
            q.delete();
            m_row = 0;
            m_col = 0;
            m_ovr = 1'b0;
            started = 1'b1;
        end else if (started && bus.ena) begin
            if (bus.rw) begin
                if (busy_now) m_ovr = 1'b1;
                else model_write(bus.addr[0], bus.wdata[7:0]);
            end else begin
                m_ovr = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus_wr(input logic a0, input logic [31:0] d);
        @(posedge clk); #1;
        bus.ena = 1'b1; bus.rw = 1'b1; bus.addr = {31'd0, a0}; bus.wdata = d;
        @(posedge clk); #1;
        bus.ena = 1'b0; bus.rw = 1'b0;
    endtask

    task automatic bus_rd();
        @(posedge clk); #1;
        bus.ena = 1'b1; bus.rw = 1'b0; bus.addr = 32'd0;
        @(posedge clk); #1;
        bus.ena = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            if (!bus.rdata[31]) return;
            n++;
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_idle: busy for %0d cycles, required idle", n);
    endtask

    task automatic put(input logic [7:0] c);
        int n;
        bus_wr(1'b0, {24'd0, c});
        wait_idle(n);
    endtask

    task automatic check_buffer(input string name);
        int bad;
        int first;
        bad = 0;
        first = -1;
        @(negedge clk);
        for (int i = 0; i < C * R; i++) begin
            if (tb_mem[i] !== exp_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s: %0d cells differ, first at %0d got %h expected %h",
                     name, bad, first, tb_mem[first], exp_mem[first]);
        end
    endtask

    function automatic logic [31:0] cursor(input int r, input int c);
        return {19'd0, 5'(r), 1'b0, 7'(c)};
    endfunction

    initial begin
        int n;
        int blanks;
        bus.ena = 1'b0; bus.rw = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rdata", bus.rdata, 32'h0000_0000);
        chk("reset_we", {31'd0, buf_we}, 32'd0);

        // First character lands at cell 0 one cycle after the write.
        bus_wr(1'b0, 32'h41);
        @(negedge clk);
        chk("put_we", {31'd0, buf_we}, 32'd1);
        chk("put_waddr", {20'd0, buf_waddr}, 32'd0);
        chk("put_wdata", {24'd0, buf_wdata}, 32'h41);
        wait_idle(n);
        chk("put_col", {25'd0, bus.rdata[6:0]}, 32'd1);
        chk("put_busy", {31'd0, bus.rdata[31]}, 32'd0);

        // Full row wraps to the next line; CR and BS at column 0.
        bus_wr(1'b1, 32'h2); wait_idle(n);
        for (int i = 0; i < C; i++) put(8'h42);
        chk("row_last_cell", {24'd0, tb_mem[69]}, 32'h42);
        chk("row_wrap_cursor", {19'd0, bus.rdata[12:0]}, cursor(1, 0));
        put(8'h0D); put(8'h08);
        chk("cr_bs_col0", {19'd0, bus.rdata[12:0]}, cursor(1, 0));
        put(8'h43); put(8'h08); put(8'h07);
        chk("bs_after_char", {19'd0, bus.rdata[12:0]}, cursor(1, 0));

        // Line feed on the bottom row.
        bus_wr(1'b1, 32'h2); wait_idle(n);
        for (int i = 0; i < R - 1; i++) put(8'h0A);
        for (int i = 0; i < 5; i++) put(8'(8'h30 + i));
        chk("bottom_cursor", {19'd0, bus.rdata[12:0]}, cursor(29, 5));
        bus_wr(1'b0, 32'h0A);
        @(negedge clk);
`ifdef TERM_SCROLL_EN
        chk("scroll_first_raddr", {20'd0, buf_raddr}, 32'd70);
        chk("scroll_first_we", {31'd0, buf_we}, 32'd0);
        wait_idle(n);
        chk("scroll_busy_cycles", n + 1, 32'd4130);
        chk("scroll_cursor", {19'd0, bus.rdata[12:0]}, cursor(29, 0));
        blanks = 0;
        for (int i = 2030; i < 2100; i++) if (tb_mem[i] == 8'h20) blanks++;
        chk("scroll_blank_row", blanks, 32'd70);
        chk("scroll_moved_cell0", {24'd0, tb_mem[0]}, 32'h43);
`else
        chk("wrap_busy", {31'd0, bus.rdata[31]}, 32'd0);
        chk("wrap_we", {31'd0, buf_we}, 32'd0);
        chk("wrap_cursor", {19'd0, bus.rdata[12:0]}, cursor(0, 0));
`endif
        check_buffer("buffer_after_lf");

        // Character put into the very last cell.
        bus_wr(1'b1, 32'h2); wait_idle(n);
        for (int i = 0; i < R - 1; i++) put(8'h0A);
        for (int i = 0; i < C; i++) put(8'h61);
`ifdef TERM_SCROLL_EN
        chk("last_cell_scroll_cursor", {19'd0, bus.rdata[12:0]}, cursor(29, 0));
        chk("last_cell_moved", {24'd0, tb_mem[2029]}, 32'h61);
        chk("last_cell_blank", {24'd0, tb_mem[2099]}, 32'h20);
`else
        chk("last_cell_wrap_cursor", {19'd0, bus.rdata[12:0]}, cursor(0, 0));
        chk("last_cell_char", {24'd0, tb_mem[2099]}, 32'h61);
`endif
        check_buffer("buffer_after_last_cell");

        // Write while busy is dropped and flagged; a read clears the flag.
        bus_wr(1'b1, 32'h1);
        bus_wr(1'b0, 32'h45);
        @(negedge clk);
        chk("ovr_set", {31'd0, bus.rdata[30]}, 32'd1);
        wait_idle(n);
        chk("ovr_sticky", {31'd0, bus.rdata[30]}, 32'd1);
        bus_rd();
        @(negedge clk);
        chk("ovr_cleared", {31'd0, bus.rdata[30]}, 32'd0);
        check_buffer("buffer_after_drop");

        // Full clear length, with both control bits set.
        put(8'h58);
        bus_wr(1'b1, 32'h3);
        wait_idle(n);
        chk("clear_cycles", n, 32'd2100);
        chk("clear_cursor", {19'd0, bus.rdata[12:0]}, cursor(0, 0));
        check_buffer("buffer_after_clear");

        // Reset aborts a clear after its 100th write.
        put(8'h0A);
        for (int i = 0; i < 40; i++) put(8'h5A);
        bus_wr(1'b1, 32'h1);
        repeat (99) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_we", {31'd0, buf_we}, 32'd0);
        chk("abort_rdata", bus.rdata, 32'h0000_0000);
        chk("abort_cell99", {24'd0, tb_mem[99]}, 32'h20);
        chk("abort_cell100", {24'd0, tb_mem[100]}, 32'h5A);
        check_buffer("buffer_after_abort");

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/term_ctrl.md
TERM_CTRL -- requirements
Module: term_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 70, meaning characters per row.
REQ-002 SHALL have parameter ROWS, default 30, meaning rows on screen; buffer cell index = row*COLS+col.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ena  input  1  bus access strobe, one access per cycle.
REQ-006 SHALL have port rw  input  1  access direction: MEM_WRITE = write, otherwise read.
REQ-007 SHALL have port addr  input  DATA_BUS  register select; only addr[0] is decoded (0 = DATA, 1 = CTRL).
REQ-008 SHALL have port wdata  input  DATA_BUS  write data.
REQ-009 SHALL have port rdata  output  DATA_BUS  combinational status word.
REQ-010 SHALL have port buf_we  output  1  character buffer write enable.
REQ-011 SHALL have port buf_waddr  output  12  buffer write index.
REQ-012 SHALL have port buf_wdata  output  8  buffer write character.
REQ-013 SHALL have port buf_raddr  output  12  buffer read index.
REQ-014 SHALL have port buf_rdata  input  8  buffer read data, valid one cycle after buf_raddr.

Function
REQ-015 rdata SHALL be {busy, ovr, 17'b0, row[4:0], 1'b0, col[6:0]} for any addr; busy = (state != IDLE).
REQ-016 A DATA or CTRL write SHALL be accepted only in IDLE; a write while busy SHALL be dropped and SHALL set sticky ovr.
REQ-017 A read (ena, rw != MEM_WRITE) SHALL clear ovr at that edge; a simultaneous dropped write elsewhere is impossible (one access per cycle).
REQ-018 States: IDLE, PUT, SCR_RD, SCR_WR, FILL.
REQ-019 A DATA write with wdata[7:0] in 0x20..0x7E SHALL enter PUT; in PUT: buf_we=1, buf_waddr=row*COLS+col, buf_wdata=latched char, for exactly one cycle.
REQ-020 PUT exit: if col<COLS-1, col+1 -> IDLE; otherwise col=0 and, if row<ROWS-1, row+1 -> IDLE, else start scroll.
REQ-021 DATA 0x0A SHALL set col=0, row+1 -> IDLE if row<ROWS-1, else start scroll; no buffer write.
REQ-022 DATA 0x0D SHALL set col=0; DATA 0x08 SHALL decrement col if col>0 (row unchanged, no erase); all other codes ignored; all three stay IDLE.
REQ-023 Scroll: index i from 0 to COLS*(ROWS-1)-1; SCR_RD drives buf_raddr=i+COLS; next cycle SCR_WR drives buf_we=1, buf_waddr=i, buf_wdata=buf_rdata; 2 cycles per cell.
REQ-024 After the last copy, FILL SHALL write 0x20 to indices COLS*(ROWS-1)..COLS*ROWS-1, one per cycle, then IDLE; row stays ROWS-1, col=0.
REQ-025 CTRL write with wdata[0]=1 SHALL set row=col=0 and FILL indices 0..COLS*ROWS-1 with 0x20, then IDLE; wdata[1]=1 alone SHALL home cursor only, staying IDLE; wdata[0] wins if both are set.
REQ-026 buf_we SHALL be 0 in IDLE and SCR_RD; buf_raddr is don't-care outside SCR_RD.
REQ-027 Index arithmetic SHALL be 12-bit unsigned; COLS*ROWS <= 4096 is required.

Reset
REQ-028 On rst: state=IDLE, row=0, col=0, ovr=0, buf_we=0, index=0; buffer contents untouched.
REQ-029 rst asserted mid scroll or fill SHALL abort at that edge with no further buf_we; partially moved contents remain.

Configuration
REQ-030 Macro TERM_SCROLL_EN: when defined, overflow past row ROWS-1 performs the scroll of REQ-023/024.
REQ-031 When TERM_SCROLL_EN is undefined: overflow sets row=0, col=0, no copy or fill; SCR_RD/SCR_WR unreachable; CTRL clear still works.

Verification
REQ-032 After reset, write DATA 0x41 -> one cycle later buf_we=1, buf_waddr=0, buf_wdata=0x41; then rdata[6:0]=1, busy=0.
REQ-033 Write 70 chars 0x42 -> last at buf_waddr=69; cursor row=1, col=0; 0x0D then 0x08 from col 0 leaves col=0.
REQ-034 Cursor row=29 col=5, DATA 0x0A (TERM_SCROLL_EN) -> first SCR_RD buf_raddr=70, SCR_WR buf_waddr=0; busy for 4060+70 cycles; cells 2030..2099 become 0x20; cursor 29,0.
REQ-035 Write DATA while busy -> no buf_we for it, rdata[30]=1; a following read clears rdata[30] to 0.
REQ-036 CTRL 0x1 -> 2100 consecutive buf_we cycles of 0x20 at indices 0..2099; rst at cycle 100 -> buf_we=0 the next cycle, cursor 0,0.
REQ-037 Without TERM_SCROLL_EN, 0x0A at row 29 -> no buf_we, cursor 0,0, busy=0 the next cycle.
